// File: rtl/m_download_pbuf_pkg.sv
// m_download_pbuf_pkg: framing codes and FSM state encoding for the download buffer.
package dl_pkg;
    localparam logic [1:0] CTRL_NONE = 2'b00;
    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_BODY = 2'b10;
    localparam logic [1:0] CTRL_TAIL = 2'b11;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, RDY = 2'b10} dl_state_t;
endpackage

// File: rtl/m_download_pbuf_slot_dec.sv
// dl_slot_dec: flit count to one-hot slot write enable, all zeros once the message is full.
module dl_slot_dec #(
    parameter int MAX_FLITS = 11,
    parameter int CNT_W     = 8
) (
    input  logic [CNT_W-1:0]     cnt_i,
    output logic [MAX_FLITS-1:0] we_o
);
    for (genvar k = 0; k < MAX_FLITS; k++) begin : g_we
        assign we_o[k] = cnt_i == CNT_W'(k);
    end
endmodule

// File: rtl/m_download_pbuf.sv
// m_download_pbuf: flit-to-message deserialiser with ready/valid input and framing checks.
// Define M_DOWNLOAD_OVF_DET_EN to build the sticky overflow flag; otherwise err_ovf is tied low.
module m_download_pbuf
    import dl_pkg::*;
#(
    parameter int FLIT_W    = 16,
    parameter int MAX_FLITS = 11,
    parameter int CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FLIT_W-1:0]           in_flit,
    input  logic                        in_valid,
    input  logic [1:0]                  in_ctrl,
    output logic                        in_ready,
    input  logic                        mem_done_access,
    output logic                        v_msg,
    output logic [MAX_FLITS*FLIT_W-1:0] msg_flits,
    output logic [CNT_W-1:0]            msg_len,
    output logic [1:0]                  dl_state,
    output logic                        err_frame,
    output logic                        err_ovf
);
    dl_state_t                             state_q;
    logic [CNT_W-1:0]                      cnt_q;
    logic [MAX_FLITS-1:0][FLIT_W-1:0]      slots_q;
    logic [MAX_FLITS-1:0]                  we;
    logic                                  err_frame_q;
    logic                                  acc;
    logic                                  room;

    assign in_ready  = state_q != RDY;
    assign acc       = in_valid && in_ready;
    assign room      = cnt_q < CNT_W'(MAX_FLITS);
    assign v_msg     = state_q == RDY;
    assign msg_len   = v_msg ? cnt_q : '0;
    assign msg_flits = slots_q;
    assign dl_state  = state_q;
    assign err_frame = err_frame_q;

    dl_slot_dec #(.MAX_FLITS(MAX_FLITS), .CNT_W(CNT_W)) u_dec (.cnt_i(cnt_q), .we_o(we));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            slots_q     <= '0;
            err_frame_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (acc) begin
                    if (in_ctrl == CTRL_HEAD || in_ctrl == CTRL_TAIL) begin
                        slots_q[0] <= in_flit;
                        cnt_q      <= CNT_W'(1);
                        state_q    <= in_ctrl == CTRL_HEAD ? BUSY : RDY;
                    end else begin
                        err_frame_q <= 1'b1;
                    end
                end
                BUSY: if (acc) begin
                    if (in_ctrl == CTRL_HEAD) begin
                        // a stray head restarts the message from scratch
                        err_frame_q <= 1'b1;
                        slots_q     <= '0;
                        slots_q[0]  <= in_flit;
                        cnt_q       <= CNT_W'(1);
                    end else if (in_ctrl == CTRL_NONE) begin
                        err_frame_q <= 1'b1;
                    end else begin
                        for (int k = 0; k < MAX_FLITS; k++)
                            if (we[k]) slots_q[k] <= in_flit;
                        if (room) cnt_q <= cnt_q + CNT_W'(1);
                        if (in_ctrl == CTRL_TAIL) state_q <= RDY;
                    end
                end
                RDY: if (mem_done_access) begin
                    slots_q <= '0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef M_DOWNLOAD_OVF_DET_EN
    logic err_ovf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_ovf_q <= 1'b0;
        else if (state_q == BUSY && acc && in_ctrl == CTRL_BODY && !room) err_ovf_q <= 1'b1;
    end
    assign err_ovf = err_ovf_q;
`else
    assign err_ovf = 1'b0;
`endif
endmodule
